// File: rtl/spi_prog_loader.sv
// Serial program loader: gathers words from an SS-framed SPI-style stream
// and writes them to consecutive memory addresses until a terminator word arrives.
module spi_prog_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    LANES      = 1,
    parameter logic [DATA_WIDTH-1:0] END_WORD   = DATA_WIDTH'(32'h00000fff)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_ss_i,
    input  logic [LANES-1:0]      spi_mosi_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [ADDR_WIDTH:0]   word_cnt_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int                  BEATS      = DATA_WIDTH / LANES;
    localparam int                  BEAT_W     = $clog2(BEATS + 1);
    localparam logic [BEAT_W-1:0]   BEATS_FULL = BEAT_W'(BEATS);
    localparam logic [ADDR_WIDTH:0] MAX_WORDS  = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ARM,
        LOAD,
        DONE
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [BEAT_W-1:0]       beat_cnt;
    logic                    ss_q;
    logic                    term_pend;

    logic                    frame_end;
    logic                    frame_full;
    logic                    granted;
    logic                    busy;
    logic                    room;
    logic [ADDR_WIDTH:0]     cnt_after;

    // cnt_after is the word count as it will stand after this cycle's grant,
    // so a word completing in the grant cycle targets the next free address.
    always_comb begin
        frame_end  = !ss_q && spi_ss_i;
        frame_full = (beat_cnt == BEATS_FULL);
        granted    = mem_req_o && mem_gnt_i;
        busy       = mem_req_o && !mem_gnt_i;
        cnt_after  = word_cnt_o + {{ADDR_WIDTH{1'b0}}, granted};
        room       = (cnt_after != MAX_WORDS);
    end

    // NOTE: non-blocking assignments throughout, so every branch below reads
    // the previous-cycle register values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ARM;
            shift_q     <= '0;
            beat_cnt    <= '0;
            ss_q        <= 1'b1;
            term_pend   <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            word_cnt_o  <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            ss_q <= spi_ss_i;

            if (granted) begin
                mem_req_o  <= 1'b0;
                word_cnt_o <= cnt_after;
            end

            case (state)
                // A frame already running at reset release is never counted.
                ARM: begin
                    beat_cnt <= '0;
                    if (spi_ss_i) begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    if (!spi_ss_i) begin
                        if (!term_pend) begin
                            shift_q <= {shift_q[DATA_WIDTH-LANES-1:0], spi_mosi_i};
                            if (!frame_full) begin
                                beat_cnt <= beat_cnt + BEAT_W'(1);
                            end
                        end
                    end else if (frame_end) begin
                        beat_cnt <= '0;
                        if (!term_pend) begin
                            if (!frame_full) begin
                                err_o <= 1'b1;
                            end else if (shift_q == END_WORD) begin
                                if (busy) begin
                                    term_pend <= 1'b1;
                                end else begin
                                    done_o <= 1'b1;
                                    state  <= DONE;
                                end
                            end else if (busy || !room) begin
                                err_o <= 1'b1;
                            end else begin
                                mem_req_o   <= 1'b1;
                                mem_addr_o  <= cnt_after[ADDR_WIDTH-1:0];
                                mem_wdata_o <= shift_q;
                            end
                        end
                    end

                    // Terminator seen while a write was outstanding: finish after its grant.
                    if (term_pend && granted) begin
                        term_pend <= 1'b0;
                        done_o    <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    beat_cnt <= '0;
                end

                default: begin
                    state <= ARM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_prog_loader.sv
// Directed bench for spi_prog_loader: a 1-lane default instance and a
// 4-lane instance with a 4-word memory for lane packing and overflow.
module tb_spi_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ss_a = 1'b1;
    logic [0:0]  mosi_a = '0;
    logic        gnt_a = 1'b0;
    logic        req_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic [10:0] cnt_a;
    logic        done_a;
    logic        err_a;

    logic        ss_b = 1'b1;
    logic [3:0]  mosi_b = '0;
    logic        gnt_b = 1'b0;
    logic        req_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  cnt_b;
    logic        done_b;
    logic        err_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0]  wa_addr[$];
    logic [31:0] wa_data[$];
    logic [1:0]  wb_addr[$];
    logic [31:0] wb_data[$];

    always #5 clk = ~clk;

    spi_prog_loader u_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .spi_ss_i   (ss_a),
        .spi_mosi_i (mosi_a),
        .mem_req_o  (req_a),
        .mem_gnt_i  (gnt_a),
        .mem_addr_o (addr_a),
        .mem_wdata_o(wdata_a),
        .word_cnt_o (cnt_a),
        .done_o     (done_a),
        .err_o      (err_a)
    );

    spi_prog_loader #(.ADDR_WIDTH(2), .LANES(4)) u_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .spi_ss_i   (ss_b),
        .spi_mosi_i (mosi_b),
        .mem_req_o  (req_b),
        .mem_gnt_i  (gnt_b),
        .mem_addr_o (addr_b),
        .mem_wdata_o(wdata_b),
        .word_cnt_o (cnt_b),
        .done_o     (done_b),
        .err_o      (err_b)
    );

    // Record every accepted write (request and grant high at an unreset edge).
    always @(posedge clk) begin
        if (!rst && req_a && gnt_a) begin
            wa_addr.push_back(addr_a);
            wa_data.push_back(wdata_a);
        end
        if (!rst && req_b && gnt_b) begin
            wb_addr.push_back(addr_b);
            wb_data.push_back(wdata_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        ss_a = 1'b1;
        ss_b = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        wa_addr.delete();
        wa_data.delete();
        wb_addr.delete();
        wb_data.delete();
    endtask

    task automatic shift_a(input logic [31:0] w, input int beats);
        for (int i = 0; i < beats; i++) begin
            int idx = beats - 1 - i;
            ss_a      = 1'b0;
            mosi_a[0] = (idx < 32) ? w[idx] : 1'b0;
            tick();
        end
    endtask

    task automatic end_a();
        ss_a   = 1'b1;
        mosi_a = '0;
        tick();
    endtask

    task automatic send_a(input logic [31:0] w);
        shift_a(w, 32);
        end_a();
    endtask

    task automatic send_b(input logic [31:0] w);
        for (int i = 0; i < 8; i++) begin
            ss_b   = 1'b0;
            mosi_b = w[31 - 4*i -: 4];
            tick();
        end
        ss_b   = 1'b1;
        mosi_b = '0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", req_a); end
        n_cmp++; if (cnt_a !== 11'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
        n_cmp++; if ({done_a, err_a} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {done_a, err_a}); end
        n_cmp++; if ({addr_a, wdata_a} !== 42'd0) begin n_bad++; $display("FAIL reset_bus: got %h/%h want 0/0", addr_a, wdata_a); end
        // A write left pending at reset must vanish without being accepted.
        gnt_a = 1'b0;
        send_a(32'h0F0F0F0F);
        n_cmp++; if (req_a !== 1'b1) begin n_bad++; $display("FAIL pend_req: got %b want 1", req_a); end
        do_reset();
        gnt_a = 1'b1;
        tick();
        n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL pend_dropped_req: got %b want 0", req_a); end
        n_cmp++; if (wa_addr.size() !== 0) begin n_bad++; $display("FAIL pend_dropped_writes: got %0d want 0", wa_addr.size()); end
    endtask

    task automatic test_single_word();
        do_reset();
        gnt_a = 1'b1;
        shift_a(32'hDEADBEEF, 33);
        end_a();
        n_cmp++; if (req_a !== 1'b1) begin n_bad++; $display("FAIL single_req: got %b want 1", req_a); end
        n_cmp++; if (addr_a !== 10'd0) begin n_bad++; $display("FAIL single_addr: got %0d want 0", addr_a); end
        n_cmp++; if (wdata_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data: got %h want deadbeef", wdata_a); end
        tick();
        n_cmp++; if (cnt_a !== 11'd1) begin n_bad++; $display("FAIL single_cnt: got %0d want 1", cnt_a); end
        n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL single_req_drop: got %b want 0", req_a); end
        n_cmp++; if (wa_addr.size() !== 1) begin n_bad++; $display("FAIL single_writes: got %0d want 1", wa_addr.size()); end
    endtask

    task automatic test_terminator();
        do_reset();
        gnt_a = 1'b1;
        send_a(32'h11111111);
        tick();
        send_a(32'h22222222);
        tick();
        shift_a(32'h00000FFF, 32);
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL term_early_done: got %b want 0", done_a); end
        end_a();
        n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL term_done: got %b want 1", done_a); end
        n_cmp++; if (req_a !== 1'b0) begin n_bad++; $display("FAIL term_no_req: got %b want 0", req_a); end
        send_a(32'h33333333);
        tick();
        n_cmp++; if (wa_addr.size() !== 2) begin n_bad++; $display("FAIL term_writes: got %0d want 2", wa_addr.size()); end
        else begin
            n_cmp++; if ({wa_addr[0], wa_data[0]} !== {10'd0, 32'h11111111}) begin n_bad++; $display("FAIL term_w0: got %0d/%h want 0/11111111", wa_addr[0], wa_data[0]); end
            n_cmp++; if ({wa_addr[1], wa_data[1]} !== {10'd1, 32'h22222222}) begin n_bad++; $display("FAIL term_w1: got %0d/%h want 1/22222222", wa_addr[1], wa_data[1]); end
        end
        n_cmp++; if (cnt_a !== 11'd2) begin n_bad++; $display("FAIL term_cnt: got %0d want 2", cnt_a); end
    endtask

    task automatic test_short_frame();
        do_reset();
        gnt_a = 1'b1;
        shift_a(32'hABCDE, 20);
        end_a();
        tick();
        n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL short_err: got %b want 1", err_a); end
        n_cmp++; if (wa_addr.size() !== 0) begin n_bad++; $display("FAIL short_writes: got %0d want 0", wa_addr.size()); end
        send_a(32'hA5A5A5A5);
        tick();
        n_cmp++; if (wa_addr.size() !== 1) begin n_bad++; $display("FAIL short_next_writes: got %0d want 1", wa_addr.size()); end
        else begin
            n_cmp++; if ({wa_addr[0], wa_data[0]} !== {10'd0, 32'hA5A5A5A5}) begin n_bad++; $display("FAIL short_next_w: got %0d/%h want 0/a5a5a5a5", wa_addr[0], wa_data[0]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        gnt_a = 1'b0;
        send_a(32'h12345678);
        send_a(32'h9ABCDEF0);
        n_cmp++; if (req_a !== 1'b1) begin n_bad++; $display("FAIL bp_req_held: got %b want 1", req_a); end
        n_cmp++; if ({addr_a, wdata_a} !== {10'd0, 32'h12345678}) begin n_bad++; $display("FAIL bp_bus_held: got %0d/%h want 0/12345678", addr_a, wdata_a); end
        n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL bp_err: got %b want 1", err_a); end
        gnt_a = 1'b1;
        tick();
        gnt_a = 1'b0;
        tick();
        n_cmp++; if ({req_a, cnt_a} !== {1'b0, 11'd1}) begin n_bad++; $display("FAIL bp_after_gnt: got req %b cnt %0d want 0/1", req_a, cnt_a); end
        n_cmp++; if (wa_data.size() !== 1) begin n_bad++; $display("FAIL bp_writes: got %0d want 1", wa_data.size()); end

        // Grant landing on the completion edge lets the second word through.
        do_reset();
        gnt_a = 1'b0;
        send_a(32'hC0C0C0C0);
        shift_a(32'hD1D1D1D1, 32);
        gnt_a = 1'b1;
        end_a();
        n_cmp++; if ({req_a, addr_a, wdata_a} !== {1'b1, 10'd1, 32'hD1D1D1D1}) begin n_bad++; $display("FAIL coin_bus: got %b/%0d/%h want 1/1/d1d1d1d1", req_a, addr_a, wdata_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL coin_err: got %b want 0", err_a); end
        tick();
        gnt_a = 1'b0;
        n_cmp++; if (cnt_a !== 11'd2) begin n_bad++; $display("FAIL coin_cnt: got %0d want 2", cnt_a); end
        n_cmp++; if (wa_data.size() !== 2) begin n_bad++; $display("FAIL coin_writes: got %0d want 2", wa_data.size()); end
        else begin
            n_cmp++; if ({wa_addr[0], wa_data[0], wa_addr[1], wa_data[1]} !== {10'd0, 32'hC0C0C0C0, 10'd1, 32'hD1D1D1D1})
                begin n_bad++; $display("FAIL coin_w: got %0d/%h %0d/%h want 0/c0c0c0c0 1/d1d1d1d1", wa_addr[0], wa_data[0], wa_addr[1], wa_data[1]); end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        gnt_a = 1'b1;
        shift_a(32'hFFFF0000, 15);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        shift_a(32'h5555AAAA, 20);
        n_cmp++; if ({req_a, done_a, err_a} !== 3'b000) begin n_bad++; $display("FAIL mid_flags: got %b want 000", {req_a, done_a, err_a}); end
        n_cmp++; if ({cnt_a, wdata_a} !== 43'd0) begin n_bad++; $display("FAIL mid_regs: got %0d/%h want 0/0", cnt_a, wdata_a); end
        end_a();
        tick();
        n_cmp++; if ({req_a, err_a} !== 2'b00) begin n_bad++; $display("FAIL mid_ignored: got %b want 00", {req_a, err_a}); end
        send_a(32'h0BADF00D);
        n_cmp++; if ({req_a, addr_a, wdata_a} !== {1'b1, 10'd0, 32'h0BADF00D}) begin n_bad++; $display("FAIL mid_next: got %b/%0d/%h want 1/0/0badf00d", req_a, addr_a, wdata_a); end
        tick();
        n_cmp++; if (wa_addr.size() !== 1) begin n_bad++; $display("FAIL mid_writes: got %0d want 1", wa_addr.size()); end
    endtask

    task automatic test_lanes4_overflow();
        do_reset();
        gnt_b = 1'b1;
        send_b(32'hCAFEF00D);
        n_cmp++; if ({req_b, addr_b, wdata_b} !== {1'b1, 2'd0, 32'hCAFEF00D}) begin n_bad++; $display("FAIL l4_word: got %b/%0d/%h want 1/0/cafef00d", req_b, addr_b, wdata_b); end
        tick();
        send_b(32'h01020304);
        send_b(32'h05060708);
        send_b(32'h090A0B0C);
        tick();
        n_cmp++; if ({cnt_b, err_b} !== {3'd4, 1'b0}) begin n_bad++; $display("FAIL l4_full: got cnt %0d err %b want 4/0", cnt_b, err_b); end
        send_b(32'h0D0E0F10);
        tick();
        n_cmp++; if ({cnt_b, err_b, req_b} !== {3'd4, 1'b1, 1'b0}) begin n_bad++; $display("FAIL l4_overflow: got cnt %0d err %b req %b want 4/1/0", cnt_b, err_b, req_b); end
        n_cmp++; if (wb_addr.size() !== 4) begin n_bad++; $display("FAIL l4_writes: got %0d want 4", wb_addr.size()); end
        else begin
            n_cmp++; if ({wb_addr[3], wb_data[3]} !== {2'd3, 32'h090A0B0C}) begin n_bad++; $display("FAIL l4_last: got %0d/%h want 3/090a0b0c", wb_addr[3], wb_data[3]); end
        end
        send_b(32'h00000FFF);
        n_cmp++; if (done_b !== 1'b1) begin n_bad++; $display("FAIL l4_done: got %b want 1", done_b); end
        gnt_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_terminator();
        test_short_frame();
        test_backpressure();
        test_reset_midframe();
        test_lanes4_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
